rob_commit_unit: RTL

//  Retire stage directly downstream of the reorder buffer. Consumes the ROB head-commit handshake.
//  Non-excepting results go to the architectural register file through one registered write port.

---
 rtl/riscv_config_pkg.sv | 16 +
 rtl/rob_commit_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/riscv_config_pkg.sv
// Shared core configuration: XLEN/address widths, commit FSM state type
// and the default flush length used by the retire stage.
package riscv_config_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_WIDTH = 32;

  localparam int DEFAULT_COMMIT_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    RUN,
    TRAP_REQ,
    FLUSH
  } commit_state_e;

endpackage

// File: rtl/rob_commit_unit.sv
// Retire stage behind the ROB: registered RF write port, trap request to
// the CSR block, timed flush after trap ack, 64-bit retired count.
// Ports: clk_i/rst_ni; rob_* head-commit handshake in; rf_* write port;
// trap_valid/pc/cause out with trap_ack_i in; flush_o; instret_o.
// COMMIT_TRACE_EN adds trace_valid_o/trace_pc_o/trace_exc_o.
module rob_commit_unit
  import riscv_config_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int PC_WIDTH       = ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = DEFAULT_COMMIT_FLUSH_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rob_valid_i,
  output logic                      rob_ready_o,
  input  logic [PC_WIDTH-1:0]       rob_pc_i,
  input  logic [REG_ADDR_WIDTH-1:0] rob_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     rob_result_i,
  input  logic                      rob_exc_valid_i,
  input  logic [31:0]               rob_exc_cause_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      trap_valid_o,
  output logic [PC_WIDTH-1:0]       trap_pc_o,
  output logic [31:0]               trap_cause_o,
  input  logic                      trap_ack_i,
  output logic                      flush_o,
`ifdef COMMIT_TRACE_EN
  output logic                      trace_valid_o,
  output logic [PC_WIDTH-1:0]       trace_pc_o,
  output logic                      trace_exc_o,
`endif
  output logic [63:0]               instret_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  commit_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = rob_valid_i && rob_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept && rob_exc_valid_i)
          state_d = TRAP_REQ;
      end
      TRAP_REQ: begin
        if (trap_ack_i) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0)
          state_d = RUN;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Handshake and trap/flush strobes depend on state only.
  always_comb begin
    rob_ready_o  = (state_q == RUN);
    trap_valid_o = (state_q == TRAP_REQ);
    flush_o      = (state_q == FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      trap_pc_o    <= '0;
      trap_cause_o <= '0;
      instret_o    <= '0;
    end else begin
      // x0 retires but never reaches the RF
      rf_we_o <= accept && !rob_exc_valid_i
                 && (rob_rd_addr_i != '0);
      if (accept && !rob_exc_valid_i) begin
        rf_waddr_o <= rob_rd_addr_i;
        rf_wdata_o <= rob_result_i;
        instret_o  <= instret_o + 64'd1;
      end
      if (accept && rob_exc_valid_i) begin
        trap_pc_o    <= rob_pc_i;
        trap_cause_o <= rob_exc_cause_i;
      end
    end
  end

`ifdef COMMIT_TRACE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_valid_o <= 1'b0;
      trace_pc_o    <= '0;
      trace_exc_o   <= 1'b0;
    end else begin
      trace_valid_o <= accept;
      trace_exc_o   <= accept && rob_exc_valid_i;
      if (accept)
        trace_pc_o <= rob_pc_i;
    end
  end
`endif

endmodule
